asi_poll_scheduler: RTL and testbench

//  AS-i master poll sequencer. Cycles through active slave addresses 1..31. For each:

---
 rtl/asi_poll_scheduler.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_asi_poll_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/asi_poll_scheduler.sv
// AS-i master poll sequencer: scans slave addresses 1..31, issues requests, checks replies.
// Optional macro ASI_RETRY_EN: one retry per address before an error is reported.
module asi_poll_scheduler #(
  parameter int unsigned RX_TIMEOUT = 1200,
  parameter int unsigned PAUSE_CLKS = 72
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] slave_mask,
  output logic [4:0]  out_addr,
  input  logic [3:0]  out_data,
  input  logic        tx_ready,
  output logic        tx_start,
  output logic [13:0] tx_frame,
  output logic        rx_arm,
  input  logic        rx_done,
  input  logic [6:0]  rx_code,
  output logic        in_we,
  output logic [4:0]  in_addr,
  output logic [3:0]  in_data,
  output logic        err_pulse,
  output logic        cycle_done,
  output logic        busy
);

  localparam int unsigned RXW = $clog2(RX_TIMEOUT + 1);
  localparam int unsigned PW  = $clog2(PAUSE_CLKS + 1);
  localparam logic [RXW-1:0] RX_LAST    = RXW'(RX_TIMEOUT - 1);
  localparam logic [PW-1:0]  PAUSE_LAST = PW'(PAUSE_CLKS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEL    = 3'd1,
    LOAD   = 3'd2,
    SEND   = 3'd3,
    TXWAIT = 3'd4,
    RXWAIT = 3'd5,
    CHECK  = 3'd6,
    PAUSE  = 3'd7
  } state_t;

  function automatic logic even_par(input logic [10:0] bits);
    return ^bits;
  endfunction

  function automatic logic [4:0] next_addr(input logic [4:0] a);
    logic [4:0] n;
    if ((a == 5'd31) || (a == 5'd0)) begin
      n = 5'd1;
    end else begin
      n = a + 5'd1;
    end
    return n;
  endfunction

  // {ST,CB,A4..A0,I4,I3..I0,PB,EB}
  function automatic logic [13:0] build_frame(input logic [4:0] addr, input logic [3:0] data);
    logic [13:0] f;
    f        = 14'd0;
    f[11:7]  = addr;
    f[5:2]   = data;
    f[1]     = even_par(f[12:2]);
    f[0]     = 1'b1;
    return f;
  endfunction

  // {ST,I3..I0,PB,EB}: PB is even parity over the data nibble
  function automatic logic reply_ok(input logic [6:0] code);
    return (code[6] == 1'b0) && (code[0] == 1'b1) &&
           (code[1] == even_par({7'd0, code[5:2]}));
  endfunction

  state_t          state_q, state_d;
  logic [4:0]      cur_addr_q, cur_addr_d;
  logic [4:0]      miss_q, miss_d;
  logic [RXW-1:0]  rx_cnt_q, rx_cnt_d;
  logic [PW-1:0]   pause_cnt_q, pause_cnt_d;
  logic            txr_prev_q;
  logic [6:0]      rx_code_q, rx_code_d;
  logic [4:0]      out_addr_q, out_addr_d;
  logic            tx_start_q, tx_start_d;
  logic [13:0]     tx_frame_q, tx_frame_d;
  logic            rx_arm_q;
  logic            in_we_q, in_we_d;
  logic [4:0]      in_addr_q, in_addr_d;
  logic [3:0]      in_data_q, in_data_d;
  logic            err_q, err_d;
  logic            cycle_done_q, cycle_done_d;
  logic            busy_q;
  logic            fail_s;
`ifdef ASI_RETRY_EN
  logic            retry_q, retry_d;
  logic            redo_q, redo_d;
`endif

  // Next-state and registered-output decode
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    miss_d       = miss_q;
    rx_cnt_d     = rx_cnt_q;
    pause_cnt_d  = pause_cnt_q;
    rx_code_d    = rx_code_q;
    out_addr_d   = out_addr_q;
    tx_start_d   = 1'b0;
    tx_frame_d   = tx_frame_q;
    in_we_d      = 1'b0;
    in_addr_d    = in_addr_q;
    in_data_d    = in_data_q;
    err_d        = 1'b0;
    cycle_done_d = 1'b0;
    fail_s       = 1'b0;
`ifdef ASI_RETRY_EN
    retry_d      = retry_q;
    redo_d       = redo_q;
`endif
    case (state_q)
      IDLE: begin
        if (enable && (|slave_mask[31:1])) begin
          state_d = SEL;
          miss_d  = 5'd0;
        end else begin
          state_d = IDLE;
        end
      end
      SEL: begin
        cur_addr_d = next_addr(cur_addr_q);
`ifdef ASI_RETRY_EN
        retry_d    = 1'b0;
        redo_d     = 1'b0;
`endif
        if (slave_mask[cur_addr_d]) begin
          out_addr_d   = cur_addr_d;
          miss_d       = 5'd0;
          cycle_done_d = (cur_addr_q == 5'd31);
          state_d      = LOAD;
        end else if (miss_q == 5'd30) begin
          // whole ring empty: the mask was cleared while running
          miss_d  = 5'd0;
          state_d = IDLE;
        end else begin
          miss_d       = miss_q + 5'd1;
          cycle_done_d = (cur_addr_q == 5'd31);
        end
      end
      LOAD: begin
        tx_frame_d = build_frame(cur_addr_q, out_data);
        state_d    = SEND;
      end
      SEND: begin
        if (tx_ready) begin
          tx_start_d = 1'b1;
          state_d    = TXWAIT;
        end else begin
          state_d = SEND;
        end
      end
      TXWAIT: begin
        if (tx_ready && !txr_prev_q) begin
          rx_cnt_d = '0;
          state_d  = RXWAIT;
        end else begin
          state_d = TXWAIT;
        end
      end
      RXWAIT: begin
        if (rx_done) begin
          rx_code_d = rx_code;
          state_d   = CHECK;
        end else if (rx_cnt_q == RX_LAST) begin
          fail_s = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      CHECK: begin
        if (reply_ok(rx_code_q)) begin
          in_we_d     = 1'b1;
          in_addr_d   = cur_addr_q;
          in_data_d   = rx_code_q[5:2];
          pause_cnt_d = '0;
          state_d     = PAUSE;
        end else begin
          fail_s = 1'b1;
        end
      end
      PAUSE: begin
        if (pause_cnt_q == PAUSE_LAST) begin
`ifdef ASI_RETRY_EN
          if (redo_q) begin
            redo_d  = 1'b0;
            state_d = LOAD;
          end else if (enable) begin
            miss_d  = 5'd0;
            state_d = SEL;
          end else begin
            state_d = IDLE;
          end
`else
          if (enable) begin
            miss_d  = 5'd0;
            state_d = SEL;
          end else begin
            state_d = IDLE;
          end
`endif
        end else begin
          pause_cnt_d = pause_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (fail_s) begin
`ifdef ASI_RETRY_EN
      if (!retry_q) begin
        retry_d = 1'b1;
        redo_d  = 1'b1;
      end else begin
        err_d     = 1'b1;
        in_addr_d = cur_addr_q;
      end
`else
      err_d     = 1'b1;
      in_addr_d = cur_addr_q;
`endif
      pause_cnt_d = '0;
      state_d     = PAUSE;
    end else begin
      pause_cnt_d = pause_cnt_d;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cur_addr_q   <= 5'd0;
      miss_q       <= 5'd0;
      rx_cnt_q     <= '0;
      pause_cnt_q  <= '0;
      txr_prev_q   <= 1'b0;
      rx_code_q    <= 7'd0;
      out_addr_q   <= 5'd0;
      tx_start_q   <= 1'b0;
      tx_frame_q   <= 14'h0001;
      rx_arm_q     <= 1'b0;
      in_we_q      <= 1'b0;
      in_addr_q    <= 5'd0;
      in_data_q    <= 4'd0;
      err_q        <= 1'b0;
      cycle_done_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef ASI_RETRY_EN
      retry_q      <= 1'b0;
      redo_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      miss_q       <= miss_d;
      rx_cnt_q     <= rx_cnt_d;
      pause_cnt_q  <= pause_cnt_d;
      txr_prev_q   <= tx_ready;
      rx_code_q    <= rx_code_d;
      out_addr_q   <= out_addr_d;
      tx_start_q   <= tx_start_d;
      tx_frame_q   <= tx_frame_d;
      rx_arm_q     <= (state_d == RXWAIT);
      in_we_q      <= in_we_d;
      in_addr_q    <= in_addr_d;
      in_data_q    <= in_data_d;
      err_q        <= err_d;
      cycle_done_q <= cycle_done_d;
      busy_q       <= (state_d != IDLE);
`ifdef ASI_RETRY_EN
      retry_q      <= retry_d;
      redo_q       <= redo_d;
`endif
    end
  end

  assign out_addr   = out_addr_q;
  assign tx_start   = tx_start_q;
  assign tx_frame   = tx_frame_q;
  assign rx_arm     = rx_arm_q;
  assign in_we      = in_we_q;
  assign in_addr    = in_addr_q;
  assign in_data    = in_data_q;
  assign err_pulse  = err_q;
  assign cycle_done = cycle_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_asi_poll_scheduler.sv
// Scoreboard bench for asi_poll_scheduler: expected events queued by stimulus, popped by a monitor.
module tb_asi_poll_scheduler;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] slave_mask;
  logic [4:0]  out_addr;
  logic [3:0]  out_data;
  logic        tx_ready;
  logic        tx_start;
  logic [13:0] tx_frame;
  logic        rx_arm;
  logic        rx_done;
  logic [6:0]  rx_code;
  logic        in_we;
  logic [4:0]  in_addr;
  logic [3:0]  in_data;
  logic        err_pulse;
  logic        cycle_done;
  logic        busy;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] K_FRAME = 2'd0;
  localparam logic [1:0] K_WR    = 2'd1;
  localparam logic [1:0] K_ERR   = 2'd2;
  localparam logic [1:0] K_CYC   = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [13:0] val;
  } exp_t;

  exp_t sb_q[$];

  asi_poll_scheduler dut (
    .clk_in(clk_in), .rst(rst), .enable(enable), .slave_mask(slave_mask),
    .out_addr(out_addr), .out_data(out_data), .tx_ready(tx_ready),
    .tx_start(tx_start), .tx_frame(tx_frame), .rx_arm(rx_arm),
    .rx_done(rx_done), .rx_code(rx_code), .in_we(in_we), .in_addr(in_addr),
    .in_data(in_data), .err_pulse(err_pulse), .cycle_done(cycle_done), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  // output-data register file contents: data = addr[3:0] ^ 4'hB
  assign out_data = out_addr[3:0] ^ 4'hB;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [13:0] frame_of(input logic [4:0] a, input logic [3:0] d);
    logic [13:0] f;
    f = {2'b00, a, 1'b0, d, 1'b0, 1'b1};
    f[1] = ^f[12:2];
    return f;
  endfunction

  task automatic push(input logic [1:0] k, input logic [13:0] v);
    exp_t e;
    e.kind = k;
    e.val  = v;
    sb_q.push_back(e);
  endtask

  task automatic mon_event(input string name, input logic [1:0] k, input logic [13:0] v);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s: got %0h, expected no event", name, v);
    end else begin
      e = sb_q.pop_front();
      check({"kind_", name}, {30'd0, k}, {30'd0, e.kind});
      check({"val_", name}, {18'd0, v}, {18'd0, e.val});
    end
  endtask

  // monitor: compares every DUT output event against the scoreboard head
  initial begin
    forever begin
      @(negedge clk_in);
      if (rst) begin
        if (tx_start)   mon_event("frame", K_FRAME, tx_frame);
        if (in_we)      mon_event("write", K_WR, {5'd0, in_addr, in_data});
        if (err_pulse)  mon_event("err", K_ERR, {9'd0, in_addr});
        if (cycle_done) mon_event("cycle", K_CYC, 14'd0);
      end
    end
  end

  // encoder model: ready drops for 20 cycles after each start pulse
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk_in); #1;
      if (tx_start) begin
        tx_ready = 1'b0;
        repeat (20) begin @(posedge clk_in); #1; end
        tx_ready = 1'b1;
      end
    end
  end

  task automatic wait_arm();
    int k = 0;
    while (!rx_arm && k < 2000) begin @(posedge clk_in); #1; k++; end
    if (!rx_arm) check("rx_arm_wait", 32'd0, 32'd1);
  endtask

  task automatic reply(input logic [6:0] code, input int dly);
    wait_arm();
    repeat (dly) begin @(posedge clk_in); #1; end
    rx_code = code;
    rx_done = 1'b1;
    @(posedge clk_in); #1;
    rx_done = 1'b0;
  endtask

  task automatic timeout_txn();
    int n = 0;
    wait_arm();
    while (rx_arm && n < 1300) begin n++; @(posedge clk_in); #1; end
    check("rx_arm_len", n, 1200);
  endtask

  task automatic edge_reply(input logic [6:0] code);
    wait_arm();
    repeat (1199) begin @(posedge clk_in); #1; end
    rx_code = code;
    rx_done = 1'b1;
    @(posedge clk_in); #1;
    rx_done = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b0; enable = 1'b0; slave_mask = 32'd0; rx_done = 1'b0; rx_code = 7'd0;
    repeat (3) @(posedge clk_in); #1;
    check("reset_ctl", {tx_start, rx_arm, in_we, err_pulse, cycle_done, busy}, 32'd0);
    check("reset_frame", tx_frame, 32'h0001);
    check("reset_addr", {out_addr, in_addr, in_data}, 32'd0);
    rst = 1'b1;
    repeat (5) @(posedge clk_in); #1;
    check("idle_no_enable", busy, 32'd0);

    // scan 1: addr1 and addr2 good
    push(K_FRAME, 14'h00AB); push(K_WR, {5'd0, 5'd1, 4'h5});
    slave_mask = 32'h0000_0006; enable = 1'b1;
    reply(7'b0_0101_0_1, 4);
    push(K_FRAME, frame_of(5'd2, 4'h9)); push(K_WR, {5'd0, 5'd2, 4'h3});
    reply(7'b0_0011_0_1, 10);

    // scan 2: addr1 timeout, addr2 bad parity
    push(K_CYC, 14'd0); push(K_FRAME, frame_of(5'd1, 4'hA));
`ifdef ASI_RETRY_EN
    push(K_FRAME, frame_of(5'd1, 4'hA));
`endif
    push(K_ERR, 14'd1);
    timeout_txn();
`ifdef ASI_RETRY_EN
    timeout_txn();
`endif
    push(K_FRAME, frame_of(5'd2, 4'h9));
`ifdef ASI_RETRY_EN
    push(K_FRAME, frame_of(5'd2, 4'h9));
`endif
    push(K_ERR, 14'd2);
    reply(7'b0_0101_1_1, 3);
`ifdef ASI_RETRY_EN
    reply(7'b0_0101_1_1, 3);
`endif

    // scan 3: rx_done on the timeout cycle wins; addr2 reply with ST=1
    push(K_CYC, 14'd0); push(K_FRAME, frame_of(5'd1, 4'hA)); push(K_WR, {5'd0, 5'd1, 4'hC});
    edge_reply(7'b0_1100_0_1);
    push(K_FRAME, frame_of(5'd2, 4'h9));
`ifdef ASI_RETRY_EN
    push(K_FRAME, frame_of(5'd2, 4'h9));
`endif
    push(K_ERR, 14'd2);
    reply(7'b1_0110_0_1, 2);
`ifdef ASI_RETRY_EN
    reply(7'b1_0110_0_1, 2);
`endif
    slave_mask = 32'h0000_0060;

    // enable dropped during RXWAIT of addr5
    push(K_FRAME, frame_of(5'd5, 4'hE)); push(K_WR, {5'd0, 5'd5, 4'h9});
    wait_arm();
    enable = 1'b0;
    reply(7'b0_1001_0_1, 3);
    n = 0;
    while (!in_we && n < 100) begin @(posedge clk_in); #1; n++; end
    check("in_we_seen", in_we, 32'd1);
    check("busy_in_pause", busy, 32'd1);
    n = 0;
    while (busy && n < 200) begin @(posedge clk_in); #1; n++; end
    check("pause_len", n, 72);
    repeat (20) @(posedge clk_in); #1;
    check("stays_idle", {busy, rx_arm}, 32'd0);
    push(K_FRAME, frame_of(5'd6, 4'hD)); push(K_WR, {5'd0, 5'd6, 4'h6});
    enable = 1'b1;
    reply(7'b0_0110_0_1, 2);

    // async reset during TXWAIT of addr5
    push(K_CYC, 14'd0); push(K_FRAME, frame_of(5'd5, 4'hE));
    n = 0;
    while (!tx_start && n < 500) begin @(posedge clk_in); #1; n++; end
    n = 0;
    while (tx_ready && n < 10) begin @(posedge clk_in); #1; n++; end
    check("in_txwait", {tx_ready, busy}, 32'd1);
    #3 rst = 1'b0;
    #1;
    check("async_rst_ctl", {tx_start, rx_arm, in_we, err_pulse, cycle_done, busy}, 32'd0);
    check("async_rst_frame", tx_frame, 32'h0001);
    check("async_rst_addr", out_addr, 32'd0);
    slave_mask = 32'h0000_0022;
    push(K_FRAME, frame_of(5'd1, 4'hA)); push(K_WR, {5'd0, 5'd1, 4'h5});
    #20 rst = 1'b1;
    reply(7'b0_0101_0_1, 2);
    enable = 1'b0;
    n = 0;
    while (busy && n < 300) begin @(posedge clk_in); #1; n++; end
    check("final_idle", busy, 32'd0);
    check("sb_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
